// File: rtl/cell_chk_pkg.sv
// ---------------------------------------------------------------------------
// cell_chk_pkg
//   Shared types and constants for the standard-cell vector checker.
//   - state_e      : sweep controller states
//   - TT_*         : reference truth tables for common 3-input cells, bit v is
//                    the expected Y when the input vector {C,B,A} equals v
//   - SYNC_STAGES  : depth of the Y synchronizer
// ---------------------------------------------------------------------------
package cell_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    localparam logic [7:0] TT_NAND3 = 8'h7F;
    localparam logic [7:0] TT_AND3  = 8'h80;
    localparam logic [7:0] TT_NOR3  = 8'h01;
    localparam logic [7:0] TT_OR3   = 8'hFE;
    localparam logic [7:0] TT_INV_A = 8'h55;

    localparam int SYNC_STAGES = 2;

endpackage : cell_chk_pkg

// File: rtl/cell_vector_checker_sync2.sv
// ---------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer bringing the asynchronous CUT output into the
//   checker clock domain. Both stages reset to 0.
//   Ports:
//     clk   : destination clock
//     rst_n : asynchronous active-low reset
//     d     : asynchronous input
//     q     : synchronized output (SYNC_STAGES cycles of latency)
// ---------------------------------------------------------------------------
module sync2
    import cell_chk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule : sync2

// File: rtl/cell_vector_checker.sv
// ---------------------------------------------------------------------------
// cell_vector_checker
//   Exhaustive stimulus-and-check stage for an N_IN-input standard cell.
//   Walks DRV through every input vector, holds each one SETTLE_CYCLES+2
//   cycles (two of them cover the Y synchronizer), samples the synchronized
//   Y once, and compares it against EXPECT_TT.
//   Ports:
//     CLK      : clock, rising edge
//     R        : asynchronous active-low reset
//     START    : begin a sweep (only looked at while idle)
//     Y        : CUT output, asynchronous to CLK
//     DRV      : CUT input vector, DRV[0]=A, DRV[1]=B, DRV[2]=C
//     BUSY     : sweep in progress
//     DONE     : one-cycle pulse, results valid
//     PASS     : last sweep matched EXPECT_TT on every vector
//     ERR_CNT  : number of mismatching vectors in the last sweep
//     FAIL_VEC : first mismatching vector (valid when ERR_CNT != 0)
//     CAPTURE  : observed truth table, bit v = sampled Y for vector v
// ---------------------------------------------------------------------------
module cell_vector_checker
    import cell_chk_pkg::*;
#(
    parameter int                    N_IN          = 3,
    parameter int                    SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0]    EXPECT_TT     = TT_NAND3
) (
    input  logic                 CLK,
    input  logic                 R,
    input  logic                 START,
    input  logic                 Y,
    output logic [N_IN-1:0]      DRV,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [N_IN:0]        ERR_CNT,
    output logic [N_IN-1:0]      FAIL_VEC,
    output logic [2**N_IN-1:0]   CAPTURE
);

    localparam int NV       = 2**N_IN;
    // The hold counter runs 0..SETTLE_CYCLES+1 while in DRIVE.
    localparam int CNT_W    = $clog2(SETTLE_CYCLES + 2);
    localparam int CNT_LAST = SETTLE_CYCLES + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   drv_q, drv_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
    logic [NV-1:0]     capture_q, capture_d;

    logic              y_sync;
    logic              mismatch;

    sync2 u_sync_y (
        .clk   (CLK),
        .rst_n (R),
        .d     (Y),
        .q     (y_sync)
    );

    // Case inequality so that an unknown Y in simulation is a mismatch.
    assign mismatch = (y_sync !== EXPECT_TT[drv_q]);

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement leaves one unassigned (which would infer a
    // latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drv_d      = drv_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;
        capture_d  = capture_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d    = ST_DRIVE;
                    cnt_d      = '0;
                    drv_d      = '0;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    fail_vec_d = '0;
                    capture_d  = '0;
                end
            end

            ST_DRIVE: begin
                if (cnt_q == CNT_W'(CNT_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                capture_d[drv_q] = y_sync;
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + (N_IN+1)'(1);
                    // First mismatch is judged on the count before this one.
                    if (err_cnt_q == '0) begin
                        fail_vec_d = drv_q;
                    end
                end
                if (&drv_q) begin
                    // PASS is settled on entry to REPORT so it is valid with DONE.
                    state_d = ST_REPORT;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    drv_d   = drv_q + N_IN'(1);
                    state_d = ST_DRIVE;
                end
            end

            ST_REPORT: begin
                drv_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the reset is asynchronous, so an aborted sweep is discarded the
    // moment R falls rather than at the next clock edge.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drv_q      <= '0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vec_q <= '0;
            capture_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drv_q      <= drv_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
            capture_q  <= capture_d;
        end
    end

    assign DRV      = drv_q;
    assign BUSY     = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign DONE     = (state_q == ST_REPORT);
    assign PASS     = pass_q;
    assign ERR_CNT  = err_cnt_q;
    assign FAIL_VEC = fail_vec_q;
    assign CAPTURE  = capture_q;

endmodule : cell_vector_checker

// File: tb/tb_cell_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_cell_vector_checker
//   Two checker instances: dut_a with default settings, dut_b with
//   SETTLE_CYCLES=0. Each drives a behavioural CUT whose output is looked up
//   from a truth table (or forced unknown). Expected results come from a
//   table-level model: mismatch count, lowest mismatching vector, captured
//   table, plus the edge-count timing rules for DRV and DONE.
// ---------------------------------------------------------------------------
module tb_cell_vector_checker;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel   = 1'b0;       // 0: dut_a, 1: dut_b
    logic [7:0] tt    = 8'h7F;      // behavioural CUT truth table
    logic       xm    = 1'b0;       // CUT output unknown

    always #5 clk = ~clk;

    logic [2:0] drv_a, drv_b, fv_a, fv_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [3:0] err_a, err_b;
    logic [7:0] cap_a, cap_b;
    logic       y_a, y_b, start_a, start_b;

    assign y_a     = xm ? 1'bx : tt[drv_a];
    assign y_b     = xm ? 1'bx : tt[drv_b];
    assign start_a = sel ? 1'b0 : start;
    assign start_b = sel ? start : 1'b0;

    cell_vector_checker dut_a (
        .CLK(clk), .R(rst_n), .START(start_a), .Y(y_a),
        .DRV(drv_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
        .ERR_CNT(err_a), .FAIL_VEC(fv_a), .CAPTURE(cap_a)
    );

    cell_vector_checker #(.SETTLE_CYCLES(0)) dut_b (
        .CLK(clk), .R(rst_n), .START(start_b), .Y(y_b),
        .DRV(drv_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
        .ERR_CNT(err_b), .FAIL_VEC(fv_b), .CAPTURE(cap_b)
    );

    logic [2:0] o_drv, o_fv;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_err;
    logic [7:0] o_cap;

    always_comb begin
        o_drv  = sel ? drv_b  : drv_a;
        o_fv   = sel ? fv_b   : fv_a;
        o_busy = sel ? busy_b : busy_a;
        o_done = sel ? done_b : done_a;
        o_pass = sel ? pass_b : pass_a;
        o_err  = sel ? err_b  : err_a;
        o_cap  = sel ? cap_b  : cap_a;
    end

    int n_checks    = 0;
    int n_pass      = 0;
    int n_fail      = 0;
    int edge_cnt    = 0;
    int done_pulses = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) if (o_done === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Table-level reference: compare each observed Y with NAND3 expectation.
    task automatic model(input logic [7:0] t, input logic x, output int err,
                         output int fv, output logic [7:0] cap);
        logic [7:0] expect_tt;
        logic       obs;
        expect_tt = 8'h7F;
        err = 0;
        fv  = 0;
        for (int v = 0; v < 8; v++) begin
            obs    = x ? 1'bx : t[v];
            cap[v] = obs;
            if (obs !== expect_tt[v]) begin
                if (err == 0) fv = v;
                err++;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input logic [7:0] t, input logic x,
                             input int per, input logic repulse);
        int         k, n, at, e_err, e_fv, d0, exp_drv;
        logic       got;
        logic [7:0] e_cap;
        tt = t;
        xm = x;
        model(t, x, e_err, e_fv, e_cap);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 k = edge_cnt;
        d0 = done_pulses;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy@start"}, o_busy, 1);
        check({tag, " err cleared"}, o_err, 0);
        check({tag, " cap cleared"}, o_cap, 0);
        got = 1'b0;
        at  = -1;
        for (int i = 0; i < 8*per + 12; i++) begin
            n = edge_cnt - k;
            start = (repulse && (n == 4 || n == 19)) ? 1'b1 : 1'b0;
            if (n < 8*per) begin
                exp_drv = (n / per > 7) ? 7 : n / per;
                check($sformatf("%s drv n=%0d", tag, n), o_drv, exp_drv);
            end
            if (o_done === 1'b1 && !got) begin
                got = 1'b1;
                at  = n;
                check({tag, " busy@done"}, o_busy, 0);
                check({tag, " pass"}, o_pass, (e_err == 0));
                check({tag, " err_cnt"}, o_err, e_err);
                check({tag, " capture"}, o_cap, e_cap);
                if (e_err != 0) check({tag, " fail_vec"}, o_fv, e_fv);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done seen"}, got, 1);
        check({tag, " done edge"}, at, 8*per);
        check({tag, " done once"}, done_pulses - d0, 1);
        check({tag, " cap stable"}, o_cap, e_cap);
        check({tag, " err stable"}, o_err, e_err);
    endtask

    initial begin
        logic got;
        repeat (3) @(negedge clk);
        check("rst drv", o_drv, 0);
        check("rst busy", o_busy, 0);
        check("rst done", o_done, 0);
        check("rst err", o_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b0;
        run_sweep("nand3", 8'h7F, 1'b0, 5, 1'b0);
        run_sweep("and3",  8'h80, 1'b0, 5, 1'b0);
        run_sweep("tie1",  8'hFF, 1'b0, 5, 1'b0);
        run_sweep("repulse", 8'h7F, 1'b0, 5, 1'b1);
        run_sweep("ydx",   8'h00, 1'b1, 5, 1'b0);
        for (int r = 0; r < 4; r++)
            run_sweep($sformatf("rand%0d", r), 8'($urandom), 1'b0, 5, 1'b0);

        sel = 1'b1;
        run_sweep("s0 nand3", 8'h7F, 1'b0, 3, 1'b0);
        run_sweep("s0 rand", 8'($urandom), 1'b0, 3, 1'b0);

        // Reset in the middle of a sweep, with partial results present.
        sel = 1'b0;
        tt  = 8'h0E;
        xm  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (o_drv === 3'd4) got = 1'b1;
            else @(negedge clk);
        end
        check("mid drv4 reached", got, 1);
        check("mid err pre-reset", o_err, 1);
        rst_n = 1'b0;
        #1;
        check("arst drv", o_drv, 0);
        check("arst busy", o_busy, 0);
        check("arst done", o_done, 0);
        check("arst pass", o_pass, 0);
        check("arst err", o_err, 0);
        check("arst fv", o_fv, 0);
        check("arst cap", o_cap, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("post-rst", 8'h7F, 1'b0, 5, 1'b0);

        // START held high: a new sweep begins right after REPORT.
        @(negedge clk);
        start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) got = 1'b1;
        end
        check("held done seen", got, 1);
        @(negedge clk);
        check("held idle gap", o_busy, 0);
        @(negedge clk);
        check("held restart busy", o_busy, 1);
        check("held restart drv", o_drv, 0);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cell_vector_checker

// File: doc/cell_vector_checker.md
# cell_vector_checker

Exhaustive stimulus-and-check stage for 3-input standard cells, NAND3X1 by default. It drives every input combination onto the cell under test (CUT) and samples the CUT output through a synchronizer. It compares each sample against an expected truth table and reports the pass/fail result, the error count, the first failing vector and the captured truth table. It sits directly upstream of the CUT, feeding its A/B/C pins, and directly downstream of it, consuming Y, inside the library-validation harness of the SoC flow.

## Interface
- N_IN, 3, number of CUT inputs; DRV[0] drives A, DRV[1] drives B, DRV[2] drives C.
- SETTLE_CYCLES, 2, extra cycles each vector is held before sampling (0 allowed).
- EXPECT_TT, 8'h7F, expected Y for vector v at bit v (NAND3: 0 only at v=7); width 2^N_IN.
- CLK  input  1  single clock, rising edge.
- R  input  1  asynchronous active-low reset.
- START  input  1  begin a sweep; sampled only in IDLE.
- Y  input  1  CUT output, asynchronous to CLK.
- DRV  output  N_IN  CUT input vector.
- BUSY  output  1  sweep in progress.
- DONE  output  1  one-cycle pulse when results are valid.
- PASS  output  1  last sweep matched EXPECT_TT exactly.
- ERR_CNT  output  N_IN+1  mismatching vectors in the last sweep (0..2^N_IN, no saturation needed).
- FAIL_VEC  output  N_IN  first mismatching vector; meaningful only when ERR_CNT!=0.
- CAPTURE  output  2^N_IN  observed truth table; bit v = sampled Y for vector v.

## Operation
- States: IDLE, DRIVE, SAMPLE, REPORT.
- IDLE:
  - START=1 at an edge -> DRIVE.
  - The same edge sets DRV<=0, BUSY<=1 and clears ERR_CNT, CAPTURE, FAIL_VEC and PASS.
- DRIVE: hold DRV for exactly SETTLE_CYCLES+2 cycles (2 cover the synchronizer), then -> SAMPLE.
- SAMPLE, one cycle:
  - CAPTURE[v]<=Ysync.
  - On mismatch with EXPECT_TT[v]: ERR_CNT+=1, and FAIL_VEC<=v if this is the first mismatch.
  - If v==2^N_IN-1 -> REPORT; otherwise DRV<=v+1 -> DRIVE.
  - The first-mismatch decision uses the pre-increment ERR_CNT==0.
- REPORT, one cycle:
  - DONE=1, BUSY=0, PASS=(ERR_CNT==0), DRV<=0.
  - Then -> IDLE.
- A non-0/1 value on Ysync (simulation) counts as a mismatch; the comparison uses case inequality.
- START while BUSY is ignored, with no queuing. START held high in IDLE after REPORT starts a new sweep.
- Reset (R low, any state, any time):
  - Immediately forces IDLE and DRV=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0, CAPTURE=0, and clears the synchronizer flops.
  - A partial sweep is discarded.

## Timing
- Let edge k be the edge that samples START in IDLE.
- DRV=0 and BUSY=1 are visible after edge k.
- Vector period P = SETTLE_CYCLES+3 edges. DRV changes to v+1 at edge k+(v+1)·P.
- DONE is high for the single cycle following edge k+2^N_IN·P. With defaults this is edge k+40; with SETTLE_CYCLES=0 it is edge k+24.
- PASS, ERR_CNT, FAIL_VEC and CAPTURE are stable from DONE until the next accepted START.
- The clock period must exceed the worst CUT propagation delay. For NAND3X1 that is ≤0.12 ns, so any harness clock qualifies.
- Minimum restart gap: START accepted again at the edge after DONE.

## Structure
- Package cell_chk_pkg holds:
  - the state enum;
  - the truth-table constants TT_NAND3=8'h7F, TT_AND3=8'h80, TT_NOR3=8'h01, TT_OR3=8'hFE, TT_INV_A=8'h55;
  - the sync depth constant SYNC_STAGES=2.
- Sub-module sync2: two-flop synchronizer with asynchronous active-low reset to 0, used for Y.
- Top level contains the FSM, the settle counter (width covering SETTLE_CYCLES+2), the vector register and the result registers.

## Test plan
- NAND3X1 model on DRV/Y, START pulse -> DONE at edge k+40, PASS=1, ERR_CNT=0, CAPTURE=8'h7F.
- CUT replaced by an AND3 model -> ERR_CNT=8, FAIL_VEC=0, CAPTURE=8'h80, PASS=0.
- Y tied to 1 -> ERR_CNT=1, FAIL_VEC=7, CAPTURE=8'hFF.
- START re-pulsed at edges k+5 and k+20 -> ignored; DONE still occurs exactly once at edge k+40.
- R low for 1 cycle while DRV=4 -> all outputs at reset values immediately. A new START then sweeps from DRV=0, and DONE comes 40 edges after it.
- SETTLE_CYCLES=0 with the NAND3X1 model -> DRV changes every 3 edges, DONE at edge k+24, PASS=1.
